// File: rtl/buffer_pkg.sv
// Shared constants and elaboration helpers for the buffering blocks.
package buffer_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 64;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same edge returns the new data.
module sdp_ram
  import buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; clearing it would need DEPTH cycles or a
  // reset fan-out to every word, and the FIFO never reads an unwritten entry.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO with a registered show-ahead head, level flags,
// sticky overflow and a high-watermark.
module stream_fifo
  import buffer_pkg::*;
#(
  parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int DEPTH      = DEFAULT_DEPTH,
  localparam int LW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  input  logic [LW-1:0]         af_thresh,
  input  logic [LW-1:0]         ae_thresh,
  output logic [LW-1:0]         level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic [LW-1:0]         max_level,
  input  logic                  clear_stats
);

  localparam int AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of two and at least 4");
  end

  logic [AW-1:0]         wr_ptr, rd_ptr, rd_addr;
  logic [LW-1:0]         level_q, level_next, max_q;
  logic [DATA_WIDTH-1:0] out_q, ram_rd_data;
  logic                  af_q, ae_q, ovf_q;
  logic                  full, push, pop, ovf_event;
  logic                  head_from_input, head_from_ram;

  assign full      = (level_q == LW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (level_q != '0);
  assign push      = in_valid && !full;
  assign pop       = out_valid && out_ready;
  assign ovf_event = in_valid && full && !flush;

  // The RAM read port always prefetches the entry just behind the next head,
  // so a pop can load the head register from it without a bubble.
  assign rd_addr = rd_ptr + AW'(pop) + AW'(1);

  // A pushed word becomes head directly when the FIFO is, or is about to be, empty.
  assign head_from_input = push && ((level_q == '0) || (pop && (level_q == LW'(1))));
  assign head_from_ram   = pop && (level_q > LW'(1));

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    level_next = level_q;
    if (flush)              level_next = '0;
    else if (push && !pop)  level_next = level_q + LW'(1);
    else if (pop && !push)  level_next = level_q - LW'(1);
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (push && !flush),
    .wr_addr (wr_ptr),
    .wr_data (in_data),
    .rd_en   (!(reset || flush)),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      out_q   <= '0;
      af_q    <= (af_thresh == '0);
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      max_q   <= '0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (head_from_input)    out_q <= in_data;
        else if (head_from_ram) out_q <= ram_rd_data;
      end
      level_q <= level_next;
      af_q    <= (level_next >= af_thresh);
      ae_q    <= (level_next <= ae_thresh);
      // A new overflow in the same cycle as clear_stats still wins.
      ovf_q   <= ovf_event || (ovf_q && !clear_stats);
      if (clear_stats)             max_q <= level_next;
      else if (level_next > max_q) max_q <= level_next;
    end
  end

  assign level        = level_q;
  assign out_data     = out_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign max_level    = max_q;

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_stream_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready, clear_stats;
  logic [DW-1:0] in_data;
  logic [LW-1:0] af_thresh, ae_thresh;
  logic          in_ready, out_valid, almost_full, almost_empty, overflow;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level, max_level;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  stream_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .max_level    (max_level),
    .clear_stats  (clear_stats)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: contents as a queue plus the stats, updated at each edge.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_af, m_ae;
  int            m_max;

  always @(posedge clk) begin : model
    int n;
    bit was_full, ovf_evt;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_max = 0;
      m_af  = (af_thresh == '0);
      m_ae  = 1'b1;
    end else begin
      was_full = (mq.size() == DEPTH);
      ovf_evt  = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        ovf_evt = in_valid && was_full;
        if (out_ready && mq.size() != 0) void'(mq.pop_front());
        if (in_valid && !was_full) mq.push_back(in_data);
      end
      m_ovf = ovf_evt || (m_ovf && !clear_stats);
      n     = mq.size();
      m_max = clear_stats ? n : ((n > m_max) ? n : m_max);
      m_af  = (n >= int'(af_thresh));
      m_ae  = (n <= int'(ae_thresh));
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("level", int'(level), mq.size());
      check("in_ready", int'(in_ready), int'(mq.size() != DEPTH));
      check("out_valid", int'(out_valid), int'(mq.size() != 0));
      if (mq.size() != 0) check("out_data", int'(out_data), int'(mq[0]));
      check("almost_full", int'(almost_full), int'(m_af));
      check("almost_empty", int'(almost_empty), int'(m_ae));
      check("overflow", int'(overflow), int'(m_ovf));
      check("max_level", int'(max_level), m_max);
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_level"}, int'(level), 0);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"}, int'(out_data), 0);
    check({tag, "_af"}, int'(almost_full), int'(af_thresh == '0));
    check({tag, "_ae"}, int'(almost_empty), 1);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_max"}, int'(max_level), 0);
  endtask

  initial begin
    int p_in, p_out;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    clear_stats = 1'b0; in_data = '0; af_thresh = LW'(6); ae_thresh = LW'(1);
    cycle();
    cycle();
    reset  = 1'b0;
    cmp_en = 1'b1;
    check_reset_state("rst");

    // Fill to capacity with the consumer stalled.
    for (int i = 1; i <= DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      cycle();
      check("t1_level", int'(level), i);
      check("t1_af", int'(almost_full), int'(i >= 6));
      check("t1_head", int'(out_data), 1);
      check("t1_in_ready", int'(in_ready), int'(i < DEPTH));
    end
    in_valid = 1'b0;
    check("t1_max", int'(max_level), 8);

    // Push attempt while full with a simultaneous pop.
    in_valid = 1'b1; in_data = 16'h0009; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0; out_ready = 1'b0;
    check("t2_level", int'(level), 7);
    check("t2_overflow", int'(overflow), 1);
    check("t2_head", int'(out_data), 2);
    clear_stats = 1'b1;
    cycle();
    clear_stats = 1'b0;
    check("t2_clr_overflow", int'(overflow), 0);
    check("t2_clr_max", int'(max_level), 7);

    // Drain, then single-entry bypass paths.
    out_ready = 1'b1;
    repeat (7) cycle();
    out_ready = 1'b0;
    check("t3_empty_level", int'(level), 0);
    check("t3_empty_ae", int'(almost_empty), 1);
    in_valid = 1'b1; in_data = 16'hABCD;
    cycle();
    check("t3_valid", int'(out_valid), 1);
    check("t3_head", int'(out_data), 16'hABCD);
    in_data = 16'h1234; out_ready = 1'b1;
    cycle();
    check("t3_swap_head", int'(out_data), 16'h1234);
    check("t3_swap_level", int'(level), 1);

    // Sustained push+pop across several pointer wraps.
    for (int k = 0; k < 20; k++) begin
      in_data = DW'(k);
      cycle();
      check("t4_head", int'(out_data), k);
      check("t4_level", int'(level), 1);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    // Reach level 5 with stats restarted, then flush alongside push and pop.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h0050 + i); clear_stats = (i == 3);
      cycle();
    end
    in_valid = 1'b0; clear_stats = 1'b0;
    check("t5_level", int'(level), 5);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h0BAD;
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("t5_level_flush", int'(level), 0);
    check("t5_valid_flush", int'(out_valid), 0);
    check("t5_ae_flush", int'(almost_empty), 1);
    check("t5_ovf_flush", int'(overflow), 0);
    check("t5_max_flush", int'(max_level), 5);

    // Overflow is neither set nor cleared by a flush on a full FIFO.
    in_valid = 1'b1;
    repeat (DEPTH + 1) cycle();
    check("t5b_overflow", int'(overflow), 1);
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("t5b_ovf_kept", int'(overflow), 1);
    check("t5b_level", int'(level), 0);

    // Reset mid-stream during a push.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h0060 + i);
      cycle();
    end
    check("t6_level", int'(level), 4);
    reset = 1'b1; in_data = 16'h0077;
    cycle();
    reset = 1'b0; in_valid = 1'b0;
    check_reset_state("t6");
    in_valid = 1'b1; in_data = 16'h0042;
    cycle();
    in_valid = 1'b0;
    check("t6_head", int'(out_data), 16'h0042);
    check("t6_valid", int'(out_valid), 1);

    // Random traffic in phases biased toward full, empty, mixed and streaming.
    for (int c = 0; c < 4000; c++) begin
      case ((c / 250) % 4)
        0:       begin p_in = 90; p_out = 15; end
        1:       begin p_in = 15; p_out = 90; end
        2:       begin p_in = 50; p_out = 50; end
        default: begin p_in = 95; p_out = 95; end
      endcase
      in_valid    = ($urandom_range(99) < p_in);
      out_ready   = ($urandom_range(99) < p_out);
      in_data     = DW'($urandom);
      flush       = ($urandom_range(63) == 0);
      clear_stats = ($urandom_range(31) == 0);
      reset       = ($urandom_range(499) == 0);
      if ($urandom_range(49) == 0) af_thresh = LW'($urandom_range(DEPTH));
      if ($urandom_range(49) == 0) ae_thresh = LW'($urandom_range(DEPTH));
      cycle();
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
    cycle();
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
